// File: rtl/alien_formation_ctrl.sv
// Formation origin controller: marches the alien block sideways, steps down and reverses at the
// screen edges, and flags landing. Define ALIEN_SPEEDUP_EN to shorten the move period as aliens die.
module alien_formation_ctrl #(
  parameter int TICK_DIV  = 2000000,
  parameter int STEP_X    = 10,
  parameter int STEP_Y    = 10,
  parameter int START_COL = 40,
  parameter int START_ROW = 40,
  parameter int SCREEN_W  = 640,
  parameter int LAND_ROW  = 400,
  parameter int ALIEN_W   = 30,
  parameter int ALIEN_H   = 20,
  parameter int PITCH_X   = 40,
  parameter int PITCH_Y   = 30,
  parameter int NUM_COLS  = 10,
  parameter int NUM_ROWS  = 5
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Restart,
  input  logic                         Enable,
  input  logic [NUM_COLS*NUM_ROWS-1:0] Aliens_Grid,
  output logic [8:0]                   Aliens_Row,
  output logic [9:0]                   Aliens_Col,
  output logic                         Dir_Right,
  output logic                         Move_Tick,
  output logic                         Aliens_Landed
);

  localparam int CELLS = NUM_COLS * NUM_ROWS;
  localparam int CW    = $clog2(NUM_COLS);
  localparam int RW    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {MARCH_R, MARCH_L, LANDED} state_e;

  state_e        state_q, state_d;
  logic [8:0]    row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic [31:0]   div_q, div_d;
  logic [31:0]   period_cur;

  logic [NUM_COLS-1:0] colmask;
  logic [NUM_ROWS-1:0] rowany;
  logic [CW-1:0]       lc, rc;
  logic [RW-1:0]       rr;
  logic [11:0]         r_edge, l_edge, b_edge;
  logic                grid_any;
  logic                wrap;

`ifdef ALIEN_SPEEDUP_EN
  localparam int PW = $clog2(CELLS + 1);
  logic [31:0] period_q, period_d, period_new;
  logic [PW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CELLS; i++) pop = pop + PW'(Aliens_Grid[i]);
    if (pop >= PW'(26))      period_new = 32'(TICK_DIV);
    else if (pop >= PW'(11)) period_new = 32'(TICK_DIV) >> 1;
    else if (pop >= PW'(3))  period_new = 32'(TICK_DIV) >> 2;
    else                     period_new = 32'(TICK_DIV) >> 3;
    if (period_new == 32'd0) period_new = 32'd1;
  end

  assign period_cur = period_q;
`else
  assign period_cur = 32'(TICK_DIV);
`endif

  // Edge positions follow the surviving grid, so a cleared outer column lets the block march further.
  always_comb begin
    colmask = '0;
    rowany  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (Aliens_Grid[r*NUM_COLS+c]) begin
          colmask[c] = 1'b1;
          rowany[r]  = 1'b1;
        end
      end
    end
    lc = '0;
    rc = '0;
    rr = '0;
    for (int c = NUM_COLS - 1; c >= 0; c--) if (colmask[c]) lc = CW'(c);
    for (int c = 0; c < NUM_COLS; c++) if (colmask[c]) rc = CW'(c);
    for (int r = 0; r < NUM_ROWS; r++) if (rowany[r]) rr = RW'(r);
    grid_any = |colmask;
    r_edge = 12'(col_q) + 12'(rc) * 12'(PITCH_X) + 12'(ALIEN_W);
    l_edge = 12'(col_q) + 12'(lc) * 12'(PITCH_X);
    b_edge = 12'(row_q) + 12'(rr) * 12'(PITCH_Y) + 12'(ALIEN_H);
  end

  assign wrap = (div_q == period_cur - 32'd1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    div_d   = div_q;
    tick_d  = 1'b0;
`ifdef ALIEN_SPEEDUP_EN
    period_d = period_q;
`endif
    // An empty grid means Bullet is about to repopulate it: everything holds.
    if (state_q != LANDED && grid_any) begin
      if (b_edge >= 12'(LAND_ROW)) begin
        state_d = LANDED;
      end else if (Enable) begin
        if (wrap) begin
          div_d  = '0;
          tick_d = 1'b1;
`ifdef ALIEN_SPEEDUP_EN
          period_d = period_new;
`endif
          case (state_q)
            MARCH_R: begin
              if (r_edge + 12'(STEP_X) > 12'(SCREEN_W - 1)) begin
                row_d   = row_q + 9'(STEP_Y);
                state_d = MARCH_L;
                dir_d   = 1'b0;
              end else begin
                col_d = col_q + 10'(STEP_X);
              end
            end
            MARCH_L: begin
              if (l_edge < 12'(STEP_X) || col_q < 10'(STEP_X)) begin
                row_d   = row_q + 9'(STEP_Y);
                state_d = MARCH_R;
                dir_d   = 1'b1;
              end else begin
                col_d = col_q - 10'(STEP_X);
              end
            end
            default: ;
          endcase
        end else begin
          div_d = div_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Restart) begin
      state_q <= MARCH_R;
      row_q   <= 9'(START_ROW);
      col_q   <= 10'(START_COL);
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      div_q   <= '0;
`ifdef ALIEN_SPEEDUP_EN
      period_q <= 32'(TICK_DIV);
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
`ifdef ALIEN_SPEEDUP_EN
      period_q <= period_d;
`endif
    end
  end

  assign Aliens_Row    = row_q;
  assign Aliens_Col    = col_q;
  assign Dir_Right     = dir_q;
  assign Move_Tick     = tick_q;
  assign Aliens_Landed = (state_q == LANDED);

endmodule
